// File: rtl/char_motion_ctrl_pkg.sv
// Shared types for the character motion controller: vertical and
// sequencer states plus the fixed warp-pipe table.
package char_pkg;

    typedef enum logic [1:0] {
        GROUND = 2'd0,
        JUMP   = 2'd1,
        FALL   = 2'd2
    } vstate_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PROBE_H,
        S_WAIT_H,
        S_PROBE_V,
        S_WAIT_V,
        S_WARP_CHK
    } seq_e;

    localparam int WARP_CW    = 10;
    localparam int WARP_N_MAX = 16;
    localparam int WARP_SPAN  = 24;

    typedef logic [WARP_CW-1:0] wcoord_t;

    typedef struct packed {
        wcoord_t src_x;
        wcoord_t src_y;
        wcoord_t dst_x;
        wcoord_t dst_y;
        wcoord_t alt_x;
        wcoord_t alt_y;
        logic    has_alt;
    } warp_t;

    // src_x, src_y, dst_x, dst_y, alt_x, alt_y, has_alt
    localparam warp_t WARP_TBL [WARP_N_MAX] = '{
        '{10'd372, 10'd260, 10'd100, 10'd430, 10'd450, 10'd200, 1'b1},
        '{10'd240, 10'd350, 10'd371, 10'd270, 10'd0,   10'd0,   1'b0},
        '{10'd520, 10'd100, 10'd30,  10'd80,  10'd0,   10'd0,   1'b0},
        '{10'd560, 10'd300, 10'd610, 10'd40,  10'd330, 10'd90,  1'b1},
        '{10'd600, 10'd420, 10'd150, 10'd100, 10'd0,   10'd0,   1'b0},
        '{10'd640, 10'd50,  10'd910, 10'd300, 10'd0,   10'd0,   1'b0},
        '{10'd700, 10'd250, 10'd80,  10'd250, 10'd940, 10'd120, 1'b1},
        '{10'd760, 10'd380, 10'd420, 10'd60,  10'd0,   10'd0,   1'b0},
        '{10'd800, 10'd150, 10'd300, 10'd400, 10'd0,   10'd0,   1'b0},
        '{10'd860, 10'd460, 10'd50,  10'd20,  10'd680, 10'd30,  1'b1},
        '{10'd900, 10'd30,  10'd480, 10'd350, 10'd0,   10'd0,   1'b0},
        '{10'd0,   10'd0,   10'd0,   10'd0,   10'd0,   10'd0,   1'b0},
        '{10'd0,   10'd0,   10'd0,   10'd0,   10'd0,   10'd0,   1'b0},
        '{10'd0,   10'd0,   10'd0,   10'd0,   10'd0,   10'd0,   1'b0},
        '{10'd0,   10'd0,   10'd0,   10'd0,   10'd0,   10'd0,   1'b0},
        '{10'd0,   10'd0,   10'd0,   10'd0,   10'd0,   10'd0,   1'b0}
    };

    function automatic logic in_window(input int y, input int y0);
        return (y >= y0) && (y < y0 + WARP_SPAN);
    endfunction

endpackage

// File: rtl/char_motion_ctrl_tick_gen.sv
// Movement tick: a one-cycle pulse every TICK_DIV clocks.
module move_tick_gen #(
    parameter int TICK_DIV = 100000
) (
    input  logic sys_clk,
    input  logic RST_N,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;
    logic          wrap;

    assign wrap = (cnt_q == CW'(TICK_DIV - 1));

    always_comb begin
        tick_d = wrap;
        cnt_d  = wrap ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge sys_clk) begin
        if (!RST_N) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/char_motion_ctrl.sv
// Character motion controller: per-tick collision probes against the
// level RAM, jump/fall physics, warp pipes and death/respawn.
module char_motion_ctrl
    import char_pkg::*;
#(
    parameter int COORD_W  = 10,
    parameter int MAP_W    = 960,
    parameter int MAP_H    = 500,
    parameter int TICK_DIV = 100000,
    parameter int JUMP_H   = 64,
    parameter int RAM_LAT  = 1,
    parameter int N_WARP   = 11,
    parameter int START_X  = 220,
    parameter int START_Y  = 360,
    localparam int ADDR_W  = $clog2(MAP_W * MAP_H)
) (
    input  logic               sys_clk,
    input  logic               RST_N,
    input  logic [3:0]         mov,
    input  logic               kill,
    input  logic               alt_sel,
    output logic [ADDR_W-1:0]  blk_addr,
    output logic               blk_rd,
    input  logic               blk_data,
    output logic [COORD_W-1:0] char_x,
    output logic [COORD_W-1:0] char_y,
    output logic [1:0]         vstate,
    output logic               warped,
    output logic               died
);

    localparam int JW = $clog2(JUMP_H + 1);
    localparam logic [COORD_W-1:0] SX   = COORD_W'(START_X);
    localparam logic [COORD_W-1:0] SY   = COORD_W'(START_Y);
    localparam logic [COORD_W-1:0] XMAX = COORD_W'(MAP_W - 1);
    localparam logic [COORD_W-1:0] YMAX = COORD_W'(MAP_H - 1);
    localparam logic [JW-1:0]      JMAX = JW'(JUMP_H);

    seq_e                seq_q, seq_d;
    vstate_e             vs_q, vs_d;
    logic [COORD_W-1:0]  x_q, x_d, y_q, y_d;
    logic [COORD_W-1:0]  cx_q, cx_d, cy_q, cy_d;
    logic [JW-1:0]       jcnt_q, jcnt_d;
    logic [2:0]          wcnt_q, wcnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                rd_q, rd_d;
    logic                warped_q, warped_d;
    logic                died_q, died_d;
    logic                khold_q, khold_d;

    logic                tick;
    logic                mv_l, mv_r, h_ok, data_ok, free, probe;
    logic [COORD_W-1:0]  h_x, v_y;
    logic                hit, use_alt;
    warp_t               hit_e;
    logic                unused_down;

    move_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .sys_clk (sys_clk),
        .RST_N   (RST_N),
        .tick    (tick)
    );

    function automatic logic [ADDR_W-1:0] pix_addr(
        input logic [COORD_W-1:0] px,
        input logic [COORD_W-1:0] py
    );
        return ADDR_W'(px) + ADDR_W'(py) * ADDR_W'(MAP_W);
    endfunction

    assign unused_down = mov[2];
    assign mv_l    = mov[1] & ~mov[0];
    assign mv_r    = mov[0] & ~mov[1];
    assign h_x     = mv_l ? x_q - 1'b1 : x_q + 1'b1;
    assign h_ok    = (mv_l && x_q != '0) || (mv_r && x_q != XMAX);
    assign v_y     = (vs_q == JUMP) ? y_q - 1'b1 : y_q + 1'b1;
    assign data_ok = (wcnt_q == 3'(RAM_LAT));
    assign free    = ~blk_data;
    assign use_alt = alt_sel & hit_e.has_alt;

    // Scan downwards so the lowest matching entry is the one kept
    always_comb begin
        hit   = 1'b0;
        hit_e = '0;
        for (int i = N_WARP - 1; i >= 0; i--) begin
            if (x_q == COORD_W'(WARP_TBL[i].src_x) &&
                in_window(int'(y_q), int'(WARP_TBL[i].src_y))) begin
                hit   = 1'b1;
                hit_e = WARP_TBL[i];
            end
        end
    end

    always_comb begin
        seq_d    = seq_q;
        vs_d     = vs_q;
        x_d      = x_q;
        y_d      = y_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        jcnt_d   = jcnt_q;
        wcnt_d   = wcnt_q;
        addr_d   = addr_q;
        rd_d     = 1'b0;
        warped_d = 1'b0;
        died_d   = 1'b0;
        khold_d  = kill;
        probe    = 1'b0;

        if (kill && !khold_q) begin
            x_d    = SX;
            y_d    = SY;
            vs_d   = FALL;
            seq_d  = S_IDLE;
            wcnt_d = '0;
            died_d = 1'b1;
        end else begin
            unique case (seq_q)
                S_IDLE: begin
                    if (tick) seq_d = S_PROBE_H;
                end
                S_PROBE_H: begin
                    seq_d = S_PROBE_V;
                    if (h_ok) begin
                        cx_d   = h_x;
                        cy_d   = y_q;
                        addr_d = pix_addr(h_x, y_q);
                        rd_d   = 1'b1;
                        wcnt_d = '0;
                        seq_d  = S_WAIT_H;
                    end
                end
                S_WAIT_H: begin
                    if (data_ok) begin
                        if (free) x_d = cx_q;
                        seq_d = S_PROBE_V;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
                S_PROBE_V: begin
                    seq_d = S_WARP_CHK;
                    unique case (vs_q)
                        GROUND: begin
                            if (mov[3]) begin
                                vs_d   = JUMP;
                                jcnt_d = '0;
                            end else if (y_q == YMAX) begin
                                vs_d = FALL;
                            end else begin
                                probe = 1'b1;
                            end
                        end
                        JUMP: begin
                            if (y_q == '0 || jcnt_q == JMAX) vs_d = FALL;
                            else probe = 1'b1;
                        end
                        FALL: begin
                            if (y_q == YMAX) begin
                                x_d    = SX;
                                y_d    = SY;
                                died_d = 1'b1;
                                seq_d  = S_IDLE;
                            end else begin
                                probe = 1'b1;
                            end
                        end
                        default: vs_d = FALL;
                    endcase
                    if (probe) begin
                        cx_d   = x_q;
                        cy_d   = v_y;
                        addr_d = pix_addr(x_q, v_y);
                        rd_d   = 1'b1;
                        wcnt_d = '0;
                        seq_d  = S_WAIT_V;
                    end
                end
                S_WAIT_V: begin
                    if (data_ok) begin
                        seq_d = S_WARP_CHK;
                        unique case (vs_q)
                            GROUND: begin
                                if (free) begin
                                    y_d  = cy_q;
                                    vs_d = FALL;
                                end
                            end
                            JUMP: begin
                                if (free) begin
                                    y_d    = cy_q;
                                    jcnt_d = jcnt_q + 1'b1;
                                    if ((jcnt_q + 1'b1) == JMAX) vs_d = FALL;
                                end else begin
                                    vs_d = FALL;
                                end
                            end
                            FALL: begin
                                if (free) y_d = cy_q;
                                else vs_d = GROUND;
                            end
                            default: vs_d = FALL;
                        endcase
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
                S_WARP_CHK: begin
                    seq_d = S_IDLE;
                    if (hit) begin
                        x_d      = COORD_W'(use_alt ? hit_e.alt_x : hit_e.dst_x);
                        y_d      = COORD_W'(use_alt ? hit_e.alt_y : hit_e.dst_y);
                        vs_d     = FALL;
                        warped_d = 1'b1;
                    end
                end
                default: seq_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!RST_N) begin
            seq_q    <= S_IDLE;
            vs_q     <= FALL;
            x_q      <= SX;
            y_q      <= SY;
            cx_q     <= '0;
            cy_q     <= '0;
            jcnt_q   <= '0;
            wcnt_q   <= '0;
            addr_q   <= '0;
            rd_q     <= 1'b0;
            warped_q <= 1'b0;
            died_q   <= 1'b0;
            khold_q  <= 1'b0;
        end else begin
            seq_q    <= seq_d;
            vs_q     <= vs_d;
            x_q      <= x_d;
            y_q      <= y_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            jcnt_q   <= jcnt_d;
            wcnt_q   <= wcnt_d;
            addr_q   <= addr_d;
            rd_q     <= rd_d;
            warped_q <= warped_d;
            died_q   <= died_d;
            khold_q  <= khold_d;
        end
    end

    assign blk_addr = addr_q;
    assign blk_rd   = rd_q;
    assign char_x   = x_q;
    assign char_y   = y_q;
    assign vstate   = vs_q;
    assign warped   = warped_q;
    assign died     = died_q;

endmodule
